// File: rtl/multi_cycle_control.sv
// ---------------------------------------------------------------------------
// multi_cycle_control
//
// Main control FSM for a multi-cycle MIPS-style datapath. It sequences each
// instruction through fetch, decode and one to three execution states, and
// drives the datapath mux selects and write enables from the current state.
//
// Parameters
//   WAIT_MEM   1: FETCH and MEMRD hold until mem_ready is high.
//              0: mem_ready is ignored and treated as always high.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous, active-low reset (forces INIT)
//   op           opcode field IR[31:26]
//   mem_ready    memory read data valid this cycle
//   PCWriteCond  conditional PC write (branch)
//   PCWrite      unconditional PC write
//   IorD         memory address select: 0 = PC, 1 = ALUOut
//   MemRead      memory read strobe
//   MemWrite     memory write strobe
//   MemToReg     register write data: 0 = MDR, 1 = ALUOut
//   IRWrite      instruction register load
//   ALUSrcA      ALU A operand: 0 = PC, 1 = Rdata1
//   RegWrite     register file write enable
//   RegDst       destination register: 0 = IR[20:16], 1 = IR[15:11]
//   ALUop        00 add, 01 sub, 10 funct-decoded
//   ALUSrcB      00 Rdata2, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   PCSource     00 ALU result, 01 ALUOut, 10 jump target
//   state        current state code, for debug
//   illegal_op   one-cycle pulse the cycle after decoding an unknown opcode
// ---------------------------------------------------------------------------
module multi_cycle_control #(
    parameter int unsigned WAIT_MEM = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUop,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_INIT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q, state_d;
    logic   illegal_op_q, illegal_op_d;
    logic   mem_ok;

    // With WAIT_MEM = 0 the memory is assumed to answer in a single cycle.
    assign mem_ok = (WAIT_MEM != 0) ? mem_ready : 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_INIT;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    // Next-state and output decode. Reset drives state_q to INIT
    // asynchronously, and INIT decodes to all-zero outputs, so no write
    // enable can be active while rst is low.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        illegal_op_d = 1'b0;
        PCWriteCond  = 1'b0;
        PCWrite      = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemToReg     = 1'b0;
        IRWrite      = 1'b0;
        ALUSrcA      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        ALUop        = 2'b00;
        ALUSrcB      = 2'b00;
        PCSource     = 2'b00;

        case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // PC+4 and the IR load only commit once the read data is valid.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = mem_ok;
                IRWrite = mem_ok;
                if (mem_ok) state_d = S_DECODE;
            end

            S_DECODE: begin
                // Branch target precomputed into ALUOut while decoding.
                ALUSrcB = 2'b11;
                case (op)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d      = S_FETCH;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end

            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end

            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end

            S_MEMWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end

            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = S_FETCH;
            end

            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
                state_d = S_RWB;
            end

            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                MemToReg = 1'b1;
                state_d  = S_FETCH;
            end

            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end

            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end

            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end

            S_ADDIWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                state_d  = S_FETCH;
            end

            // Unused codes 12-14 recover to FETCH with all outputs low.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign state      = state_q;
    assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_control
//
// Self-checking bench for multi_cycle_control (WAIT_MEM = 1). A path-based
// model expands each fetched opcode into the list of states the instruction
// visits, and a per-state output table gives the required control vector.
// A compare process checks the DUT against the model on every falling edge;
// the directed sequence also pins literal state codes and output values.
// ---------------------------------------------------------------------------
module tb_multi_cycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'b000000;
    logic       mem_ready = 1'b1;

    logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] ALUop, ALUSrcB, PCSource;
    logic [3:0] state;
    logic       illegal_op;
    logic [15:0] dut_ctrl;

    int checks = 0;
    int errors = 0;

    multi_cycle_control #(.WAIT_MEM(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .mem_ready  (mem_ready),
        .PCWriteCond(PCWriteCond),
        .PCWrite    (PCWrite),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemToReg   (MemToReg),
        .IRWrite    (IRWrite),
        .ALUSrcA    (ALUSrcA),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUop      (ALUop),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .state      (state),
        .illegal_op (illegal_op)
    );

    assign dut_ctrl = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg,
                       IRWrite, ALUSrcA, RegWrite, RegDst, ALUop, ALUSrcB, PCSource};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int      m_state   = 15;
    int      m_path[$];
    bit      m_bad     = 1'b0;
    bit      m_illegal = 1'b0;

    // States an instruction visits after leaving FETCH, ending back in FETCH.
    function automatic void build_path(input logic [5:0] o);
        m_path.delete();
        m_bad = 1'b0;
        case (o)
            6'b000000: m_path = '{1, 6, 7, 0};
            6'b100011: m_path = '{1, 2, 3, 4, 0};
            6'b101011: m_path = '{1, 2, 5, 0};
            6'b000100: m_path = '{1, 8, 0};
            6'b000010: m_path = '{1, 9, 0};
            6'b001000: m_path = '{1, 10, 11, 0};
            default: begin
                m_path = '{1, 0};
                m_bad  = 1'b1;
            end
        endcase
    endfunction

    // Required control vector per state, in dut_ctrl bit order.
    function automatic logic [15:0] exp_ctrl(input int s, input logic mr);
        logic pcwc = 0, pcw = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0;
        logic irw = 0, srca = 0, rw = 0, rdst = 0;
        logic [1:0] aop = 0, srcb = 0, pcs = 0;
        case (s)
            0:  begin mrd = 1; srcb = 2'b01; pcw = mr; irw = mr; end
            1:  begin srcb = 2'b11; end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; m2r = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin srca = 1; srcb = 2'b10; end
            11: begin rw = 1; m2r = 1; end
            default: ;
        endcase
        return {pcwc, pcw, iord, mrd, mwr, m2r, irw, srca, rw, rdst, aop, srcb, pcs};
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_state   = 15;
                m_path.delete();
                m_illegal = 1'b0;
            end else begin
                bit stall;
                bit nxt_illegal;
                stall       = (m_state == 0 || m_state == 3) && !mem_ready;
                nxt_illegal = (m_state == 1) && m_bad;
                if (m_state == 15) begin
                    m_state = 0;
                end else if (!stall) begin
                    if (m_state == 0) build_path(op);
                    m_state = m_path.pop_front();
                end
                m_illegal = nxt_illegal;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int we;
        check("model_state", state, m_state);
        check("model_ctrl", dut_ctrl, exp_ctrl(m_state, mem_ready));
        check("model_illegal", illegal_op, m_illegal);
        we = PCWrite + MemWrite + RegWrite + ((state != 0) ? IRWrite : 0);
        check("one_write_enable", (we <= 1), 1);
        check("rd_wr_exclusive", MemRead & MemWrite, 0);
        if (!rst) check("no_we_in_reset", {PCWrite, MemWrite, RegWrite, IRWrite, PCWriteCond}, 0);
    end

    // ---------------- directed stimulus ----------------
    task automatic step_expect(input string name, input int code);
        @(posedge clk);
        #1;
        check(name, state, code);
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        check("reset_state", state, 15);
        check("reset_illegal", illegal_op, 0);
        check("reset_ctrl", dut_ctrl, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        check("init_hold", state, 15);

        // R-type: 15,0,1,6,7,0
        op = 6'b000000;
        step_expect("r_fetch", 0);
        step_expect("r_decode", 1);
        step_expect("r_exec", 6);
        check("r_exec_ctrl", {ALUSrcA, ALUSrcB, ALUop}, 5'b1_00_10);
        step_expect("r_rwb", 7);
        check("r_rwb_write", {RegWrite, RegDst, MemToReg}, 3'b111);
        step_expect("r_done", 0);

        // lw with three wait cycles in MEMRD: 0,1,2,3,3,3,3,4,0
        op = 6'b100011;
        step_expect("lw_decode", 1);
        step_expect("lw_memadr", 2);
        step_expect("lw_memrd", 3);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_expect("lw_memrd_wait", 3);
            check("lw_wait_no_write", {RegWrite, PCWrite, IRWrite}, 0);
        end
        mem_ready = 1'b1;
        step_expect("lw_memwb", 4);
        check("lw_memwb_write", {RegWrite, MemToReg, RegDst}, 3'b100);
        step_expect("lw_done", 0);

        // sw: 0,1,2,5,0
        op = 6'b101011;
        step_expect("sw_decode", 1);
        step_expect("sw_memadr", 2);
        step_expect("sw_memwr", 5);
        check("sw_memwr_ctrl", {MemWrite, IorD, MemRead}, 3'b110);
        step_expect("sw_done", 0);
        check("sw_memwrite_dropped", MemWrite, 0);

        // beq then j
        op = 6'b000100;
        step_expect("beq_decode", 1);
        step_expect("beq_branch", 8);
        check("beq_ctrl", {PCWriteCond, PCSource, ALUop}, 5'b1_01_01);
        step_expect("beq_done", 0);
        op = 6'b000010;
        step_expect("j_decode", 1);
        step_expect("j_jump", 9);
        check("j_ctrl", {PCWrite, PCSource}, 3'b1_10);
        step_expect("j_done", 0);

        // addi: 0,1,10,11,0
        op = 6'b001000;
        step_expect("addi_decode", 1);
        step_expect("addi_ex", 10);
        step_expect("addi_wb", 11);
        check("addi_wb_write", {RegWrite, RegDst, MemToReg}, 3'b101);
        step_expect("addi_done", 0);

        // illegal opcode: 0,1,0 with a one-cycle illegal_op pulse
        op = 6'b111111;
        step_expect("ill_decode", 1);
        check("ill_decode_no_we", {PCWrite, MemWrite, RegWrite, IRWrite, PCWriteCond}, 0);
        check("ill_not_yet", illegal_op, 0);
        step_expect("ill_back_fetch", 0);
        check("ill_pulse", illegal_op, 1);
        op = 6'b000000;
        step_expect("ill_next_decode", 1);
        check("ill_pulse_end", illegal_op, 0);
        step_expect("r2_exec", 6);
        step_expect("r2_rwb", 7);
        step_expect("r2_done", 0);

        // FETCH stall while mem_ready is low
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_expect("fetch_stall", 0);
            check("fetch_stall_ctrl", {MemRead, PCWrite, IRWrite}, 3'b100);
        end
        mem_ready = 1'b1;
        #1 check("fetch_ready_ctrl", {MemRead, PCWrite, IRWrite}, 3'b111);
        step_expect("r3_decode", 1);
        step_expect("r3_exec", 6);

        // asynchronous reset pulse in the middle of EXEC
        #2 rst = 1'b0;
        #1;
        check("async_rst_state", state, 15);
        check("async_rst_ctrl", dut_ctrl, 0);
        check("async_rst_illegal", illegal_op, 0);
        #4 rst = 1'b1;
        step_expect("post_rst_fetch", 0);
        step_expect("post_rst_decode", 1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, state=%0d", state);
        $fatal(1, "watchdog expired");
    end

endmodule
